// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Program-counter register and instruction-fetch sequencer. It fetches one
//   instruction at a time from instruction memory with a request/valid
//   handshake. Each instruction is held for an execute window, and then the PC
//   is advanced to the value chosen by the upstream branch select mux.
//
//   Sequence: IDLE -> ISSUE -> EXEC -> ISSUE -> ...
//   The unit enters HALTED when the halt word is fetched, or when a fetch
//   times out (only in the optional timeout build). It leaves HALTED only
//   through rst_n.
//
// Optional feature:
//   PC_FETCH_TIMEOUT_EN - when defined, a fetch that waits TIMEOUT_CYCLES
//   ISSUE cycles without ImemValid raises FetchErr and halts. When the macro
//   is undefined, no counter is built, FetchErr is tied low and ISSUE waits
//   indefinitely.
//
// Parameters:
//   RESET_PC        PC value loaded on reset.
//   HALT_WORD       instruction encoding that stops fetch permanently.
//   TIMEOUT_CYCLES  ISSUE cycles without ImemValid before a fetch error.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   NextPC      in  32   next PC from the branch select mux
//   Stall       in   1   hold the current instruction in EXEC
//   ImemValid   in   1   memory returned data for ImemAddr
//   ImemData    in  32   instruction word from memory
//   ImemReq     out  1   fetch request
//   ImemAddr    out 32   fetch address (always equal to PC)
//   PC          out 32   current program counter
//   PCplus4     out 32   PC + 4, 32-bit wrap
//   Instr       out 32   registered instruction
//   InstrValid  out  1   Instr valid for execution this cycle
//   Halted      out  1   sticky halt indication
//   AlignErr    out  1   sticky misaligned-NextPC indication
//   FetchErr    out  1   sticky fetch-timeout indication
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] NextPC,
    input  logic        Stall,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Halted,
    output logic        AlignErr,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        align_err_q, align_err_d;

    // The memory response is only meaningful while a request is outstanding.
    logic        fetch_done;
    logic        fetch_is_halt;
    // The EXEC window closes and the PC advances.
    logic        exec_advance;
    // The outstanding fetch has waited too long (always 0 without the feature).
    logic        timeout_hit;

    assign fetch_done    = (state_q == ST_ISSUE) && ImemValid;
    assign fetch_is_halt = (ImemData == HALT_WORD);
    assign exec_advance  = (state_q == ST_EXEC) && !Stall;

`ifdef PC_FETCH_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Fetch timeout counter
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;

    // The counter is held at zero outside ISSUE. This gives the clear on every
    // entry to ISSUE, because ISSUE is only ever entered from IDLE or EXEC.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != ST_ISSUE) begin
            wait_cnt_d = '0;
        end else if (!ImemValid) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // The timeout fires on the miss that would bring the count to
    // TIMEOUT_CYCLES. ImemValid in that same cycle takes priority, so the
    // fetch completes normally.
    assign timeout_hit = (state_q == ST_ISSUE) && !ImemValid &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign fetch_err_d = fetch_err_q | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign FetchErr = fetch_err_q;
`else
    // Without the timeout feature, the fetch waits indefinitely for memory.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign FetchErr    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Stall is deliberately ignored here; it only extends EXEC.
                if (ImemValid) begin
                    state_d = fetch_is_halt ? ST_HALTED : ST_EXEC;
                end else if (timeout_hit) begin
                    state_d = ST_HALTED;
                end
            end
            ST_EXEC: begin
                if (!Stall) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        align_err_d   = align_err_q;

        // The halt word is also captured, so Instr shows why fetch stopped.
        if (fetch_done) begin
            instr_d = ImemData;
        end

        // Low PC bits are forced to zero. A misaligned request is flagged but
        // does not stop the machine.
        if (exec_advance) begin
            pc_d = {NextPC[31:2], 2'b00};
            if (NextPC[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end

        // InstrValid is registered from the next state, so it is high in
        // exactly the EXEC cycles with no combinational path from the inputs.
        instr_valid_d = (state_d == ST_EXEC);
        halted_d      = halted_q | (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            align_err_q   <= align_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    // The request is decoded from the state register alone. It stays stable
    // through memory wait cycles, and an asynchronous reset drops it at once.
    always_comb begin
        ImemReq = (state_q == ST_ISSUE);
    end

    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCplus4    = pc_q + 32'd4;
    assign Instr      = instr_q;
    assign InstrValid = instr_valid_q;
    assign Halted     = halted_q;
    assign AlignErr   = align_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit. The bench drives inputs and samples outputs on the
// falling clock edge. The unit's outputs depend only on its registers, so a
// value sampled on the falling edge is the state after the previous rising
// edge.
//
// Parts:
//   1. Table of per-cycle vectors. It covers reset, sequential fetch, a stall,
//      a memory wait, a branch, a misaligned NextPC and a halt.
//   2. Hand-written sequences: halt persistence, reset, PC wrap, reset during
//      a fetch, and the timeout (only when PC_FETCH_TIMEOUT_EN is defined).
//   3. Random run checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] NextPC;
    logic        Stall;
    logic        ImemValid;
    logic [31:0] ImemData;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Halted;
    logic        AlignErr;
    logic        FetchErr;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .NextPC     (NextPC),
        .Stall      (Stall),
        .ImemValid  (ImemValid),
        .ImemData   (ImemData),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .PC         (PC),
        .PCplus4    (PCplus4),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Halted     (Halted),
        .AlignErr   (AlignErr),
        .FetchErr   (FetchErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The task returns on the falling edge where reset is released. At that
    // point the unit sits in IDLE, and the next rising edge moves it to ISSUE.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        Stall     = 1'b0;
        ImemValid = 1'b0;
        ImemData  = 32'h0;
        NextPC    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory image used by the random run. The top bit is always 0, so a word
    // can never equal the halt encoding.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {1'b0, addr[30:0] ^ 31'h0BAD_F00D};
    endfunction

    typedef struct {
        logic        stall;
        logic        ivalid;
        logic [31:0] idata;
        logic [31:0] next_pc;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_align;
        logic        e_halted;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_instr;
        logic        m_align;
        logic        m_in_exec;
        int          m_wait;
        int          n_retired;
        int          sel;

        rst_n     = 1'b0;
        Stall     = 1'b0;
        ImemValid = 1'b0;
        ImemData  = 32'h0;
        NextPC    = 32'h0;

        // Each record lists the inputs driven after the check, followed by the
        // outputs expected when that falling edge is sampled.
        //             stall ival  idata          next_pc      | req  pc           iv    instr          align halted
        vecs[0]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h2008_0005, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1, 32'h2008_0005, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_1111, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 32'h2008_0005, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_1111, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_2222, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_1111, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_2222, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_AAAA, 32'h0000_0100, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_2222, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_2222, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_2222, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_2222, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_3333, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_2222, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0040, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_3333, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_4444, 32'h0000_0000, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_3333, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0046, 1'b0, 32'h0000_0040, 1'b1, 32'h0000_4444, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_5555, 32'h0000_0000, 1'b1, 32'h0000_0044, 1'b0, 32'h0000_4444, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0020, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_5555, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_5555, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_0080, 1'b0, 32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b0, 32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1};

        // ---------------------------------------------------------------
        // 1. Table-driven vectors
        // ---------------------------------------------------------------
        do_reset();
        for (int i = 0; i < NV; i++) begin
            chk1 ("vec_req",    ImemReq,    vecs[i].e_req);
            chk32("vec_addr",   ImemAddr,   vecs[i].e_pc);
            chk32("vec_pc",     PC,         vecs[i].e_pc);
            chk32("vec_pcp4",   PCplus4,    vecs[i].e_pc + 32'd4);
            chk1 ("vec_ivalid", InstrValid, vecs[i].e_iv);
            chk32("vec_instr",  Instr,      vecs[i].e_instr);
            chk1 ("vec_align",  AlignErr,   vecs[i].e_align);
            chk1 ("vec_halted", Halted,     vecs[i].e_halted);
            chk1 ("vec_ferr",   FetchErr,   1'b0);
            $display("vec %0d: req=%b addr=%h iv=%b instr=%h align=%b halted=%b",
                     i, ImemReq, ImemAddr, InstrValid, Instr, AlignErr, Halted);
            Stall     = vecs[i].stall;
            ImemValid = vecs[i].ivalid;
            ImemData  = vecs[i].idata;
            NextPC    = vecs[i].next_pc;
            @(negedge clk);
        end

        // ---------------------------------------------------------------
        // 2a. HALTED persists under memory traffic and Stall activity
        // ---------------------------------------------------------------
        for (int i = 0; i < 6; i++) begin
            ImemValid = 1'b1;
            ImemData  = $urandom;
            Stall     = i[0];
            NextPC    = 32'h0000_0200;
            chk1 ("halt_hold_req",    ImemReq,    1'b0);
            chk1 ("halt_hold_halted", Halted,     1'b1);
            chk1 ("halt_hold_iv",     InstrValid, 1'b0);
            chk32("halt_hold_pc",     PC,         32'h0000_0020);
            @(negedge clk);
        end
        $display("halt hold: pc=%h halted=%b", PC, Halted);

        // ---------------------------------------------------------------
        // 2b. Reset clears the halt; PC wraps from 0xFFFFFFFC to 0
        // ---------------------------------------------------------------
        do_reset();
        chk32("rst_pc",     PC,       32'h0000_0000);
        chk1 ("rst_halted", Halted,   1'b0);
        chk1 ("rst_align",  AlignErr, 1'b0);
        chk32("rst_instr",  Instr,    32'h0000_0000);
        chk1 ("rst_req",    ImemReq,  1'b0);
        @(negedge clk);                            // ISSUE at address 0
        ImemValid = 1'b1; ImemData = 32'h0000_0077;
        @(negedge clk);                            // EXEC at address 0
        ImemValid = 1'b0; Stall = 1'b0; NextPC = 32'hFFFF_FFFC;
        @(negedge clk);                            // ISSUE at the top address
        chk32("wrap_top_addr", ImemAddr, 32'hFFFF_FFFC);
        ImemValid = 1'b1; ImemData = 32'h0000_0088;
        @(negedge clk);                            // EXEC at the top address
        chk32("wrap_top_pc",   PC,       32'hFFFF_FFFC);
        chk32("wrap_pcplus4",  PCplus4,  32'h0000_0000);
        chk32("wrap_instr",    Instr,    32'h0000_0088);
        ImemValid = 1'b0; NextPC = 32'hFFFF_FFFC + 32'd4;
        @(negedge clk);                            // ISSUE after the wrap
        chk32("wrap_addr",  ImemAddr, 32'h0000_0000);
        chk1 ("wrap_align", AlignErr, 1'b0);
        chk1 ("wrap_req",   ImemReq,  1'b1);
        $display("wrap: addr=%h align=%b", ImemAddr, AlignErr);

        // ---------------------------------------------------------------
        // 2c. Reset during an outstanding fetch; late valid ignored in IDLE
        // ---------------------------------------------------------------
        #2 rst_n = 1'b0;
        #1;
        chk1 ("midrst_req", ImemReq, 1'b0);
        chk32("midrst_pc",  PC,      32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1; ImemValid = 1'b1; ImemData = 32'h0000_0999;
        chk1 ("midrst_idle_req", ImemReq, 1'b0);
        @(negedge clk);
        chk1 ("midrst_issue_req", ImemReq,    1'b1);
        chk1 ("midrst_issue_iv",  InstrValid, 1'b0);
        chk32("midrst_instr",     Instr,      32'h0000_0000);
        ImemValid = 1'b0;
        $display("mid-fetch reset: req=%b instr=%h", ImemReq, Instr);

`ifdef PC_FETCH_TIMEOUT_EN
        // ---------------------------------------------------------------
        // 2d. Fetch timeout, and valid arriving on the last allowed cycle
        // ---------------------------------------------------------------
        do_reset();
        @(negedge clk);                            // ISSUE cycle 1
        for (int k = 1; k <= 16; k++) begin
            chk1("to_req",    ImemReq,  1'b1);
            chk1("to_ferr0",  FetchErr, 1'b0);
            chk1("to_halt0",  Halted,   1'b0);
            ImemValid = 1'b0;
            @(negedge clk);
        end
        chk1("to_ferr",   FetchErr, 1'b1);
        chk1("to_halted", Halted,   1'b1);
        chk1("to_req_off", ImemReq, 1'b0);
        $display("timeout: ferr=%b halted=%b", FetchErr, Halted);

        do_reset();
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            chk1("to2_req", ImemReq, 1'b1);
            ImemValid = (k == 16);
            ImemData  = 32'h0000_1234;
            @(negedge clk);
        end
        ImemValid = 1'b0;
        chk1 ("to2_iv",     InstrValid, 1'b1);
        chk1 ("to2_ferr",   FetchErr,   1'b0);
        chk1 ("to2_halted", Halted,     1'b0);
        chk32("to2_instr",  Instr,      32'h0000_1234);
        $display("timeout race: iv=%b ferr=%b", InstrValid, FetchErr);
`endif

        // ---------------------------------------------------------------
        // 3. Random run against a transaction-level model
        //    After reset the unit alternates between two phases: waiting for
        //    the fetch at m_pc, and executing m_instr. The PC moves only when
        //    an execute window closes.
        // ---------------------------------------------------------------
        do_reset();
        @(negedge clk);
        m_pc      = 32'h0000_0000;
        m_instr   = 32'h0000_0000;
        m_align   = 1'b0;
        m_in_exec = 1'b0;
        m_wait    = 0;
        n_retired = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk1("rnd_align",  AlignErr, m_align);
            chk1("rnd_halted", Halted,   1'b0);
            chk1("rnd_ferr",   FetchErr, 1'b0);
            chk32("rnd_pc",    PC,       m_pc);
            chk32("rnd_pcp4",  PCplus4,  m_pc + 32'd4);
            chk32("rnd_instr", Instr,    m_instr);
            NextPC = $urandom;
            Stall  = 1'($urandom_range(0, 1));
            if (!m_in_exec) begin
                chk1 ("rnd_req",  ImemReq,    1'b1);
                chk32("rnd_addr", ImemAddr,   m_pc);
                chk1 ("rnd_iv0",  InstrValid, 1'b0);
                if ($urandom_range(0, 2) != 0 || m_wait >= 8) begin
                    ImemValid = 1'b1;
                    ImemData  = mem_word(m_pc);
                    m_instr   = ImemData;
                    m_in_exec = 1'b1;
                    m_wait    = 0;
                end else begin
                    ImemValid = 1'b0;
                    ImemData  = $urandom;
                    m_wait++;
                end
            end else begin
                chk1("rnd_req0", ImemReq,    1'b0);
                chk1("rnd_iv1",  InstrValid, 1'b1);
                ImemValid = 1'($urandom_range(0, 1));
                ImemData  = $urandom;
                Stall     = ($urandom_range(0, 3) == 0);
                sel = $urandom_range(0, 9);
                if (sel < 5)       NextPC = m_pc + 32'd4;
                else if (sel < 8)  NextPC = $urandom & 32'hFFFF_FFFC;
                else if (sel == 8) NextPC = 32'hFFFF_FFFC;
                else               NextPC = $urandom;
                if (!Stall) begin
                    $display("retire %0d: pc=%h instr=%h next=%h", n_retired, m_pc, m_instr, NextPC);
                    n_retired++;
                    if (NextPC[1:0] != 2'b00) m_align = 1'b1;
                    m_pc      = NextPC & 32'hFFFF_FFFC;
                    m_in_exec = 1'b0;
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
